// File: rtl/stereo_pkg.sv
// Shared constants for the stereo auto-panner: pan mode encodings
// and triangle direction values. No ports.
package stereo_pkg;

    localparam logic [1:0] MODE_MANUAL   = 2'd0;
    localparam logic [1:0] MODE_TRIANGLE = 2'd1;
    localparam logic [1:0] MODE_SAW      = 2'd2;
    localparam logic [1:0] MODE_BEAT     = 2'd3;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/stereo_autopan_if.sv
// Sample stream bundle: mono sample in (sample_valid, codec_sample),
// split stereo out (out_valid, codec_sample_left/right).
interface stereo_autopan_if #(
    parameter int SAMPLE_W = 16
);

    logic                       sample_valid;
    logic signed [SAMPLE_W-1:0] codec_sample;
    logic                       out_valid;
    logic signed [SAMPLE_W-1:0] codec_sample_left;
    logic signed [SAMPLE_W-1:0] codec_sample_right;

    modport master (
        output sample_valid, codec_sample,
        input  out_valid, codec_sample_left, codec_sample_right
    );

    modport slave (
        input  sample_valid, codec_sample,
        output out_valid, codec_sample_left, codec_sample_right
    );

endinterface

// File: rtl/pan_lfo.sv
// Pan position generator: step timer, beat edge detect, mode-change
// detect and p/dir state. In: mode, manual_pan, beat. Out: p.
module pan_lfo
    import stereo_pkg::*;
#(
    parameter int GAIN_W      = 4,
    parameter int STEP_PERIOD = 250000000,
    parameter int CNT_W       = 40
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      mode,
    input  logic [GAIN_W:0] manual_pan,
    input  logic            beat,
    output logic [GAIN_W:0] p
);

    localparam int PW = GAIN_W + 1;
    localparam logic [PW-1:0] PMAX = PW'(2 ** GAIN_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_PERIOD - 1);

    logic [PW-1:0]    p_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             beat_q;
    logic [1:0]       mode_q;
    logic             mode_chg, timed, cnt_end, tick;
    logic [PW-1:0]    manual_clamp, p_clamp;

    assign mode_chg = (mode != mode_q);
    assign timed    = (mode == MODE_TRIANGLE) || (mode == MODE_SAW);
    assign cnt_end  = (cnt_q == CNT_LAST);
    // A tick coinciding with a mode change is dropped.
    assign tick     = !mode_chg &&
                      ((timed && cnt_end) ||
                       (mode == MODE_BEAT && beat && !beat_q));

    assign manual_clamp = (manual_pan > PMAX) ? PMAX : manual_pan;
    assign p_clamp      = (p > PMAX) ? PMAX : p;

    always_comb begin
        p_d   = p;
        dir_d = dir_q;
        cnt_d = '0;
        if (timed && !mode_chg && !cnt_end)
            cnt_d = cnt_q + CNT_W'(1);
        if (mode_chg) begin
            p_d   = p_clamp;
            dir_d = DIR_UP;
        end else if (mode == MODE_MANUAL) begin
            p_d = manual_clamp;
        end else if (tick) begin
            if (mode == MODE_SAW) begin
                p_d = (p == PMAX) ? '0 : p + PW'(1);
            end else if (dir_q == DIR_UP && p != PMAX) begin
                p_d = p + PW'(1);
                if (p_d == PMAX) dir_d = DIR_DOWN;
            end else begin
                // Also covers entering a triangle at PMAX heading up.
                p_d   = p - PW'(1);
                dir_d = (p_d == '0) ? DIR_UP : DIR_DOWN;
            end
        end
    end

    dffr #(.W(PW))    u_p    (.clk(clk), .rst_n(reset), .d(p_d),   .q(p));
    dffr #(.W(1))     u_dir  (.clk(clk), .rst_n(reset), .d(dir_d), .q(dir_q));
    dffr #(.W(CNT_W)) u_cnt  (.clk(clk), .rst_n(reset), .d(cnt_d), .q(cnt_q));
    dffr #(.W(1))     u_beat (.clk(clk), .rst_n(reset), .d(beat),  .q(beat_q));
    dffr #(.W(2))     u_mode (.clk(clk), .rst_n(reset), .d(mode),  .q(mode_q));

endmodule

// File: rtl/stereo_dff.sv
// Flop cells with synchronous active-low reset to zero.
// Ports: clk, rst_n, optional en, d in, q out (W bits).
module dffr #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (!rst_n) q <= '0;
        else        q <= d;
    end
endmodule

module dffre #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (!rst_n)  q <= '0;
        else if (en) q <= d;
    end
endmodule

// File: rtl/stereo_autopan.sv
// Mono to stereo auto-panner, 2-cycle pipeline, left = s*p/PMAX,
// right = s - left. Ports: clk, reset, mode, manual_pan, beat, pan_pos, bus.
module stereo_autopan #(
    parameter int SAMPLE_W    = 16,
    parameter int GAIN_W      = 4,
    parameter int STEP_PERIOD = 250000000,
    parameter int CNT_W       = 40
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      mode,
    input  logic [GAIN_W:0] manual_pan,
    input  logic            beat,
    output logic [GAIN_W:0] pan_pos,
    stereo_autopan_if.slave bus
);

    localparam int PW = SAMPLE_W + GAIN_W + 2;

    logic [GAIN_W:0]            p, p1;
    logic signed [SAMPLE_W-1:0] s1, left_d, right_d;
    logic                       v1;
    logic signed [PW-1:0]       s_ext, p_ext, prod;

    pan_lfo #(
        .GAIN_W(GAIN_W),
        .STEP_PERIOD(STEP_PERIOD),
        .CNT_W(CNT_W)
    ) u_lfo (
        .clk(clk),
        .reset(reset),
        .mode(mode),
        .manual_pan(manual_pan),
        .beat(beat),
        .p(p)
    );

    assign pan_pos = p;

    dffre #(.W(SAMPLE_W)) u_s1 (.clk(clk), .rst_n(reset),
        .en(bus.sample_valid), .d(bus.codec_sample), .q(s1));
    dffre #(.W(GAIN_W+1)) u_p1 (.clk(clk), .rst_n(reset),
        .en(bus.sample_valid), .d(p), .q(p1));
    dffr #(.W(1)) u_v1 (.clk(clk), .rst_n(reset),
        .d(bus.sample_valid), .q(v1));

    // p is non-negative, so the product never exceeds |s| * PMAX;
    // taking bits [GAIN_W +: SAMPLE_W] is the arithmetic shift.
    assign s_ext   = {{(GAIN_W+2){s1[SAMPLE_W-1]}}, s1};
    assign p_ext   = {{(SAMPLE_W+1){1'b0}}, p1};
    assign prod    = s_ext * p_ext;
    assign left_d  = prod[GAIN_W +: SAMPLE_W];
    assign right_d = s1 - left_d;

    dffre #(.W(SAMPLE_W)) u_left (.clk(clk), .rst_n(reset),
        .en(v1), .d(left_d), .q(bus.codec_sample_left));
    dffre #(.W(SAMPLE_W)) u_right (.clk(clk), .rst_n(reset),
        .en(v1), .d(right_d), .q(bus.codec_sample_right));
    dffr #(.W(1)) u_ov (.clk(clk), .rst_n(reset),
        .d(v1), .q(bus.out_valid));

endmodule

// File: tb/tb_stereo_autopan.sv
// Scoreboard bench for stereo_autopan: sample split results and
// pan position sequences in all four modes.
module tb_stereo_autopan;

    localparam int SW   = 16;
    localparam int GW   = 4;
    localparam int STEP = 4;
    localparam int PMAX = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    mode;
    logic [GW:0]   manual_pan;
    logic          beat;
    logic [GW:0]   pan_pos;

    int errors = 0;
    int checks = 0;
    longint q_l[$];
    longint q_r[$];

    stereo_autopan_if #(.SAMPLE_W(SW)) bus ();

    stereo_autopan #(
        .SAMPLE_W(SW),
        .GAIN_W(GW),
        .STEP_PERIOD(STEP),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .mode(mode),
        .manual_pan(manual_pan),
        .beat(beat),
        .pan_pos(pan_pos),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got,
                       input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    function automatic longint ref_left(input longint s, input longint p);
        return (s * p) >>> GW;
    endfunction

    task automatic send(input int s, input int p);
        bus.codec_sample = SW'(s);
        bus.sample_valid = 1'b1;
        q_l.push_back(ref_left(s, p));
        q_r.push_back(s - ref_left(s, p));
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.sample_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_change(output int n, output int v);
        logic [GW:0] prev;
        prev = pan_pos;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (pan_pos == prev && n < 40);
        if (pan_pos == prev) chk("step_timeout", n, -1);
        v = int'(pan_pos);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                if (q_l.size() == 0) begin
                    chk("sb_extra", 1, 0);
                end else begin
                    chk("left", bus.codec_sample_left, q_l.pop_front());
                    chk("right", bus.codec_sample_right, q_r.pop_front());
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, v, exp_p;
        bit up, wrapped;
        logic signed [SW-1:0] r16;

        reset = 1'b0;
        mode = 2'd0;
        manual_pan = '0;
        beat = 1'b0;
        bus.sample_valid = 1'b1;
        bus.codec_sample = 16'h7FFF;
        repeat (3) @(negedge clk);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_left", bus.codec_sample_left, 0);
        chk("rst_right", bus.codec_sample_right, 0);
        chk("rst_pan", pan_pos, 0);

        reset = 1'b1;
        q_l.push_back(ref_left(32767, 0));
        q_r.push_back(32767 - ref_left(32767, 0));
        @(negedge clk);
        chk("lat1_valid", bus.out_valid, 0);
        bus.sample_valid = 1'b0;
        @(negedge clk);
        chk("lat2_valid", bus.out_valid, 1);

        manual_pan = 5'd8;
        idle(3);
        chk("man_pan8", pan_pos, 8);
        send(16'h4000, 8);
        manual_pan = 5'd31;
        idle(3);
        chk("man_clamp", pan_pos, PMAX);
        send(16'h4000, PMAX);
        send(-32768, PMAX);
        manual_pan = 5'd1;
        idle(3);
        send(-1, 1);
        send(1, 1);
        manual_pan = 5'd5;
        idle(3);
        for (int i = 0; i < 12; i++) begin
            r16 = SW'($urandom);
            send(int'(r16), 5);
        end
        idle(4);

        manual_pan = '0;
        idle(3);
        chk("pan_zero", pan_pos, 0);

        // Triangle: first step lands one cycle later, since the mode
        // register sees the change one edge after it is driven.
        mode = 2'd1;
        exp_p = 0;
        up = 1'b1;
        for (int k = 0; k < 34; k++) begin
            if (up) begin
                exp_p++;
                if (exp_p == PMAX) up = 1'b0;
            end else begin
                exp_p--;
                if (exp_p == 0) up = 1'b1;
            end
            wait_change(n, v);
            chk("tri_val", v, exp_p);
            chk("tri_gap", n, (k == 0) ? STEP + 1 : STEP);
        end

        mode = 2'd2;
        wrapped = 1'b0;
        for (int k = 0; k < 40; k++) begin
            exp_p = (exp_p == PMAX) ? 0 : exp_p + 1;
            if (exp_p == 0) wrapped = 1'b1;
            wait_change(n, v);
            chk("saw_val", v, exp_p);
            chk("saw_gap", n, (k == 0) ? STEP + 1 : STEP);
            if (wrapped && exp_p == 5) break;
        end

        mode = 2'd1;
        wait_change(n, v);
        chk("sw_tri_val", v, 6);
        chk("sw_tri_gap", n, STEP + 1);

        mode = 2'd3;
        idle(2);
        beat = 1'b1;
        idle(10);
        beat = 1'b0;
        idle(3);
        chk("beat_hold", pan_pos, 7);
        beat = 1'b1;
        idle(1);
        beat = 1'b0;
        idle(2);
        beat = 1'b1;
        idle(1);
        beat = 1'b0;
        idle(3);
        chk("beat_pulses", pan_pos, 9);

        mode = 2'd1;
        beat = 1'b1;
        idle(1);
        beat = 1'b0;
        idle(1);
        beat = 1'b1;
        idle(1);
        beat = 1'b0;
        chk("tri_beat_ign", pan_pos, 9);
        wait_change(n, v);
        chk("tri_after_beat", v, 10);

        idle(5);
        chk("sb_drain", q_l.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
